// File: rtl/systolic_feeder_4x4.sv
`default_nettype none
// ============================================================================
// Module      : systolic_feeder_4x4
// Description : Load-side scheduler for the 4x4 int8 systolic array. Buffers
//               one A/B operand pair, pulses the array reset, streams skewed
//               rows of A / columns of B, flushes, then pulses done.
// Revision    : 1.0  initial release
// ============================================================================
module systolic_feeder_4x4 #(
    parameter int N            = 4,
    parameter int DATA_W       = 8,
    parameter int FLUSH_CYCLES = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [N*N*DATA_W-1:0]    a_in,
    input  logic [N*N*DATA_W-1:0]    b_in,
    output logic                     arr_rst,
    output logic [N*DATA_W-1:0]      x_o,
    output logic [N*DATA_W-1:0]      y_o,
    output logic                     busy,
    output logic                     done
);

    // One counter serves both the stream steps and the flush cycles.
    localparam int                 c_cnt_w       = (2*N-1+FLUSH_CYCLES > 1) ?
                                                   $clog2(2*N-1+FLUSH_CYCLES) : 1;
    localparam logic [c_cnt_w-1:0] c_step_last   = c_cnt_w'(2*N-2);
    localparam logic [c_cnt_w-1:0] c_flush_last  = c_cnt_w'(FLUSH_CYCLES-1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_CLEAR  = 2'd1,
        S_STREAM = 2'd2,
        S_FLUSH  = 2'd3
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [c_cnt_w-1:0]      r_cnt;
    logic [c_cnt_w-1:0]      w_cnt_nxt;
    logic [N*N*DATA_W-1:0]   r_a_buf;
    logic [N*N*DATA_W-1:0]   r_b_buf;
    logic                    w_accept;
    logic                    w_drive;
    logic                    w_arr_rst_nxt;
    logic                    w_done_nxt;
    logic [N*DATA_W-1:0]     w_x_nxt;
    logic [N*DATA_W-1:0]     w_y_nxt;

    assign in_ready = (r_state == S_IDLE);
    assign busy     = !in_ready;
    assign w_accept = in_valid && in_ready;

    // Operand buffers: captured only on the accept edge, ignored otherwise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a_buf <= '0;
            r_b_buf <= '0;
        end else if (w_accept) begin
            r_a_buf <= a_in;
            r_b_buf <= b_in;
        end
    end

    // Next-state logic; w_drive marks edges that load a stream step into x_o/y_o.
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_arr_rst_nxt = 1'b0;
        w_done_nxt    = 1'b0;
        w_drive       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_nxt   = S_CLEAR;
                    w_cnt_nxt     = '0;
                    w_arr_rst_nxt = 1'b1;
                end
            end
            S_CLEAR: begin
                w_state_nxt = S_STREAM;
                w_cnt_nxt   = '0;
                w_drive     = 1'b1;
            end
            S_STREAM: begin
                if (r_cnt == c_step_last) begin
                    w_state_nxt = S_FLUSH;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                    w_drive   = 1'b1;
                end
            end
            S_FLUSH: begin
                if (r_cnt == c_flush_last) begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = '0;
                    w_done_nxt  = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // Skew: at step t, row i carries A[i][k] and column i carries B[k][i] where k = t - i.
    always_comb begin
        w_x_nxt = '0;
        w_y_nxt = '0;
        if (w_drive) begin
            for (int i = 0; i < N; i++) begin
                for (int k = 0; k < N; k++) begin
                    if (w_cnt_nxt == c_cnt_w'(i + k)) begin
                        w_x_nxt[i*DATA_W +: DATA_W] = r_a_buf[(i*N+k)*DATA_W +: DATA_W];
                        w_y_nxt[i*DATA_W +: DATA_W] = r_b_buf[(k*N+i)*DATA_W +: DATA_W];
                    end
                end
            end
        end
    end

    // State and registered outputs; reset holds the array in reset until the first edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            arr_rst <= 1'b1;
            x_o     <= '0;
            y_o     <= '0;
            done    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            arr_rst <= w_arr_rst_nxt;
            x_o     <= w_x_nxt;
            y_o     <= w_y_nxt;
            done    <= w_done_nxt;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_systolic_feeder_4x4.sv
`default_nettype none
// ============================================================================
// Module      : tb_systolic_feeder_4x4
// Description : Self-checking bench for systolic_feeder_4x4. A phase-based
//               model (cycles since accept) predicts every output; the array
//               product is rebuilt from the observed streams and compared with
//               a plain matrix multiply.
// Revision    : 1.0  initial release
// ============================================================================
module tb_systolic_feeder_4x4;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         in_valid = 1'b0;
    logic [127:0] a_in = '0;
    logic [127:0] b_in = '0;
    logic         in_ready;
    logic         arr_rst;
    logic [31:0]  x_o;
    logic [31:0]  y_o;
    logic         busy;
    logic         done;

    systolic_feeder_4x4 dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a_in     (a_in),
        .b_in     (b_in),
        .arr_rst  (arr_rst),
        .x_o      (x_o),
        .y_o      (y_o),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [127:0] a;
        logic [127:0] b;
        logic [255:0] c;
    } vec_t;

    vec_t               tv [4];
    int                 n_err = 0;
    int                 n_chk = 0;
    int                 phase = 100;   // cycles since last accept; >=12 means idle
    int                 cyc   = 0;
    int                 n_acc = 0;
    int                 prev_acc = -1;
    bit                 b2b_mode = 1'b0;
    logic signed [7:0]  ma [4][4];
    logic signed [7:0]  mb [4][4];
    logic signed [7:0]  xs [7][4];
    logic signed [7:0]  ys [7][4];
    logic [255:0]       last_prod;
    int                 row2_exp [7] = '{0, 0, 20, 21, 22, 23, 0};

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s (cycle %0d): got %0h expected %0h", nm, cyc, act, exp);
        end
    endtask

    task automatic fail_now(input string nm);
        n_chk++;
        n_err++;
        $display("FAIL %s (cycle %0d): bound expired", nm, cyc);
    endtask

    // One clock: note acceptance, advance the model, compare every output.
    task automatic cycle();
        bit           acc;
        logic [31:0]  ex;
        logic [31:0]  ey;
        logic [255:0] recon;
        logic [255:0] refp;
        int           t;
        int           s;
        int           r;
        acc = in_valid && (phase >= 12);
        if (acc) begin
            for (int i = 0; i < 4; i++)
                for (int j = 0; j < 4; j++) begin
                    ma[i][j] = a_in[(i*4+j)*8 +: 8];
                    mb[i][j] = b_in[(i*4+j)*8 +: 8];
                end
        end
        @(posedge clk);
        #1;
        cyc++;
        if (acc) begin
            if (b2b_mode && prev_acc >= 0) chk("b2b_gap", 64'(cyc - prev_acc), 64'd12);
            prev_acc = cyc;
            n_acc++;
            phase = 1;
        end else if (phase < 100) begin
            phase++;
        end

        ex = '0;
        ey = '0;
        if (phase >= 2 && phase <= 8) begin
            t = phase - 2;
            for (int i = 0; i < 4; i++) begin
                r = t - i;
                if (r >= 0 && r < 4) begin
                    ex[i*8 +: 8] = ma[i][r];
                    ey[i*8 +: 8] = mb[r][i];
                end
                xs[t][i] = x_o[i*8 +: 8];
                ys[t][i] = y_o[i*8 +: 8];
            end
        end
        chk("ctrl{arr_rst,done,in_ready,busy}", {arr_rst, done, in_ready, busy},
            {phase == 1, phase == 12, phase >= 12, phase < 12});
        chk("x_o", x_o, ex);
        chk("y_o", y_o, ey);

        if (phase == 12) begin
            for (int i = 0; i < 4; i++)
                for (int j = 0; j < 4; j++) begin
                    s = 0;
                    for (int k = 0; k < 4; k++)
                        s += int'(xs[i+k][i]) * int'(ys[k+j][j]);
                    recon[(i*4+j)*16 +: 16] = 16'(s);
                    s = 0;
                    for (int k = 0; k < 4; k++)
                        s += int'(ma[i][k]) * int'(mb[k][j]);
                    refp[(i*4+j)*16 +: 16] = 16'(s);
                end
            for (int i = 0; i < 4; i++)
                chk("product_row", recon[i*64 +: 64], refp[i*64 +: 64]);
            last_prod = recon;
        end
    endtask

    task automatic wait_idle();
        for (int n = 0; n < 40 && phase < 12; n++) cycle();
        if (phase < 12) fail_now("idle_timeout");
    endtask

    task automatic run_op(input logic [127:0] a, input logic [127:0] b);
        wait_idle();
        a_in     = a;
        b_in     = b;
        in_valid = 1'b1;
        cycle();
        in_valid = 1'b0;
        a_in     = {$urandom, $urandom, $urandom, $urandom};
        b_in     = {$urandom, $urandom, $urandom, $urandom};
        for (int n = 0; n < 20 && phase != 12; n++) cycle();
        if (phase != 12) fail_now("done_timeout");
    endtask

    initial begin
        logic [127:0] a0, b0, a1, b1, a2, b2, a3, b3;
        logic [255:0] c0, c1, c2, c3;
        int           start;
        logic [7:0]   tmp;

        // Directed table: operands with hand-derived products.
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) begin
                int idx;
                idx = i*4 + j;
                a0[idx*8 +: 8]  = (i == j) ? 8'd1 : 8'd0;
                b0[idx*8 +: 8]  = 8'(4*i + j + 1);
                c0[idx*16 +: 16] = 16'(4*i + j + 1);
                a1[idx*8 +: 8]  = 8'(10*i + j);
                b1[idx*8 +: 8]  = 8'd0;
                c1[idx*16 +: 16] = 16'd0;
                a2[idx*8 +: 8]  = 8'h80;
                b2[idx*8 +: 8]  = 8'h80;
                c2[idx*16 +: 16] = 16'd0;
                a3[idx*8 +: 8]  = 8'd1;
                b3[idx*8 +: 8]  = 8'(i - j);
                c3[idx*16 +: 16] = 16'(6 - 4*j);
            end
        tv[0] = '{a: a0, b: b0, c: c0};
        tv[1] = '{a: a1, b: b1, c: c1};
        tv[2] = '{a: a2, b: b2, c: c2};
        tv[3] = '{a: a3, b: b3, c: c3};

        // Reset values.
        #2 rst = 1'b1;
        #1;
        chk("rst_ctrl{arr_rst,done,busy,in_ready}", {arr_rst, done, busy, in_ready}, 4'b1001);
        chk("rst_x_o", x_o, 64'd0);
        chk("rst_y_o", y_o, 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst   = 1'b0;
        phase = 100;
        cycle();

        // Directed table.
        for (int v = 0; v < 4; v++) begin
            run_op(tv[v].a, tv[v].b);
            for (int r = 0; r < 4; r++)
                chk("tbl_prod_row", last_prod[r*64 +: 64], tv[v].c[r*64 +: 64]);
            if (v == 1) begin
                for (int t = 0; t < 7; t++) begin
                    tmp = xs[t][2];
                    chk("row2_seq", tmp, 8'(row2_exp[t]));
                end
            end
        end

        // in_valid held high: back-to-back accepts every 12 cycles.
        wait_idle();
        start    = n_acc;
        prev_acc = -1;
        b2b_mode = 1'b1;
        in_valid = 1'b1;
        for (int n = 0; n < 30; n++) begin
            a_in = {$urandom, $urandom, $urandom, $urandom};
            b_in = {$urandom, $urandom, $urandom, $urandom};
            cycle();
        end
        in_valid = 1'b0;
        b2b_mode = 1'b0;
        chk("b2b_count", 64'(n_acc - start), 64'd3);
        wait_idle();

        // Reset in the middle of STREAM (t=3).
        a_in     = {$urandom, $urandom, $urandom, $urandom};
        b_in     = {$urandom, $urandom, $urandom, $urandom};
        in_valid = 1'b1;
        cycle();
        in_valid = 1'b0;
        while (phase < 5) cycle();
        #1 rst = 1'b1;
        #1;
        chk("abort_ctrl{arr_rst,done,busy,in_ready}", {arr_rst, done, busy, in_ready}, 4'b1001);
        chk("abort_x_o", x_o, 64'd0);
        chk("abort_y_o", y_o, 64'd0);
        @(posedge clk);
        #1;
        chk("abort_hold{arr_rst,done,busy,in_ready}", {arr_rst, done, busy, in_ready}, 4'b1001);
        @(negedge clk);
        rst   = 1'b0;
        phase = 100;
        repeat (15) cycle();
        run_op({$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom});

        // Random operands with random in_valid gaps.
        start = n_acc;
        for (int n = 0; n < 40000 && (n_acc - start) < 1000; n++) begin
            in_valid = ($urandom_range(0, 1) == 1);
            a_in     = {$urandom, $urandom, $urandom, $urandom};
            b_in     = {$urandom, $urandom, $urandom, $urandom};
            cycle();
        end
        in_valid = 1'b0;
        if ((n_acc - start) < 1000) fail_now("random_ops");
        wait_idle();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
